// File: rtl/game_pkg.sv
// Shared types and helpers for the tap game round logic.
// State encoding, saturating count type and target rule.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    JUDGE = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam int CW = 5;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t SAT_MAX = 5'd31;

  function automatic cnt_t target_f(
    input logic [3:0] lvl,
    input int         base
  );
    int t;
    t = base + 2 * int'(lvl);
    if (t > int'(SAT_MAX)) t = int'(SAT_MAX);
    if (t < 0) t = 0;
    return cnt_t'(t);
  endfunction

  function automatic cnt_t sat_inc(
    input cnt_t c,
    input logic inc
  );
    if (inc && (c != SAT_MAX)) return c + 5'd1;
    return c;
  endfunction

  // Both operands are <= SAT_MAX, so the
  // magnitude never exceeds the saturation limit.
  function automatic cnt_t abs_diff(
    input cnt_t a,
    input cnt_t b
  );
    if (a > b) return a - b;
    return b - a;
  endfunction

endpackage

// File: rtl/round_timer.sv
// Loadable down-counter with an expiry flag.
// Used for round length and verdict timeout.
module round_timer #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Load wins; otherwise step down while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  // Expiry is the last enabled cycle at zero.
  always_comb begin
    expire_o = en_i && (cnt_q == '0);
  end

endmodule

// File: rtl/round_controller.sv
// Round sequencer: counts taps for a fixed window,
// reports the miss distance and applies the verdict.
module round_controller
  import game_pkg::*;
#(
  parameter int TICKS_PER_ROUND = 16,
  parameter int MAX_LEVEL       = 7,
  parameter int RESP_TIMEOUT    = 8,
  parameter int BASE_TARGET     = 3
) (
  input  logic       Clk100M,
  input  logic       Rst_n,
  input  logic       start,
  input  logic       tap,
  input  logic       incLevel,
  input  logic       lose,
  output logic       levelComplete,
  output logic [4:0] difference,
  output logic [3:0] level,
  output logic [4:0] target,
  output logic       running,
  output logic       gameOver,
  output logic       won
);

  localparam int RW = $clog2(TICKS_PER_ROUND) + 1;
  localparam int TW = $clog2(RESP_TIMEOUT) + 1;

  localparam logic [RW-1:0] RND_LOAD =
    RW'(TICKS_PER_ROUND - 1);
  localparam logic [TW-1:0] RSP_LOAD =
    TW'(RESP_TIMEOUT - 1);
  localparam logic [3:0] LVL_MAX = 4'(MAX_LEVEL);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] level_q;
  logic [3:0] level_d;
  logic       won_q;
  logic       won_d;
  logic       lc_q;
  logic       lc_d;
  cnt_t       diff_q;
  cnt_t       diff_d;
  cnt_t       taps_q;
  cnt_t       taps_d;
  cnt_t       target_q;
  cnt_t       target_d;
  cnt_t       taps_fin;

  logic rnd_load;
  logic rnd_en;
  logic rnd_exp;
  logic rsp_load;
  logic rsp_en;
  logic rsp_exp;
  logic verdict_ok;

  round_timer #(
    .W (RW)
  ) u_rnd_timer (
    .clk_i      (Clk100M),
    .rst_ni     (Rst_n),
    .load_i     (rnd_load),
    .load_val_i (RND_LOAD),
    .en_i       (rnd_en),
    .expire_o   (rnd_exp)
  );

  round_timer #(
    .W (TW)
  ) u_rsp_timer (
    .clk_i      (Clk100M),
    .rst_ni     (Rst_n),
    .load_i     (rsp_load),
    .load_val_i (RSP_LOAD),
    .en_i       (rsp_en),
    .expire_o   (rsp_exp)
  );

  // State register.
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, level and win flag.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    won_d   = won_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          level_d = '0;
          won_d   = 1'b0;
        end
      end
      RUN: begin
        if (rnd_exp) state_d = JUDGE;
      end
      JUDGE: begin
        if (verdict_ok && lose) begin
          state_d = OVER;
          won_d   = 1'b0;
        end else if (verdict_ok && incLevel) begin
          if (level_q >= LVL_MAX) begin
            state_d = OVER;
            won_d   = 1'b1;
          end else begin
            state_d = RUN;
            level_d = level_q + 4'd1;
          end
        end else if (rsp_exp) begin
          state_d = RUN;
        end
      end
      OVER: begin
        if (start) begin
          state_d = IDLE;
          won_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State decodes and timer controls. The judge
  // cannot answer in the levelComplete cycle, so
  // verdicts are accepted only after it.
  always_comb begin
    running    = (state_q == RUN);
    gameOver   = (state_q == OVER);
    rnd_en     = (state_q == RUN);
    rsp_en     = (state_q == JUDGE);
    verdict_ok = rsp_en && !lc_q;
    rnd_load   = (state_d == RUN) && (state_q != RUN);
    rsp_load   = rnd_exp;
  end

  // Tap count, round result and target next values.
  always_comb begin
    taps_fin = sat_inc(taps_q, tap);
    taps_d   = taps_q;
    if (rnd_load)
      taps_d = '0;
    else if (state_q == RUN)
      taps_d = taps_fin;
    lc_d   = rnd_exp;
    diff_d = diff_q;
    if (rnd_exp)
      diff_d = abs_diff(target_q, taps_fin);
    target_d = target_f(level_d, BASE_TARGET);
  end

  // Datapath registers.
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      level_q  <= '0;
      won_q    <= 1'b0;
      lc_q     <= 1'b0;
      diff_q   <= '0;
      taps_q   <= '0;
      target_q <= target_f(4'd0, BASE_TARGET);
    end else begin
      level_q  <= level_d;
      won_q    <= won_d;
      lc_q     <= lc_d;
      diff_q   <= diff_d;
      taps_q   <= taps_d;
      target_q <= target_d;
    end
  end

  assign levelComplete = lc_q;
  assign difference    = diff_q;
  assign level         = level_q;
  assign target        = target_q;
  assign won           = won_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed + randomized bench for round_controller
// against a behavioural game model.
module tb_round_controller;

  logic       Clk100M = 1'b0;
  logic       Rst_n;
  logic       start, tap, incLevel, lose;
  logic       levelComplete;
  logic [4:0] difference;
  logic [3:0] level;
  logic [4:0] target;
  logic       running, gameOver, won;

  logic       start2, tap2;
  logic       lc2;
  logic [4:0] diff2;
  logic [3:0] level2;
  logic [4:0] target2;
  logic       running2, gameOver2, won2;

  int checks   = 0;
  int failures = 0;
  int m_level;
  bit m_won;
  bit m_over;
  int g_diff;

  always #5 Clk100M = ~Clk100M;

  round_controller u_dut (
    .Clk100M       (Clk100M),
    .Rst_n         (Rst_n),
    .start         (start),
    .tap           (tap),
    .incLevel      (incLevel),
    .lose          (lose),
    .levelComplete (levelComplete),
    .difference    (difference),
    .level         (level),
    .target        (target),
    .running       (running),
    .gameOver      (gameOver),
    .won           (won)
  );

  round_controller #(
    .TICKS_PER_ROUND (48)
  ) u_sat (
    .Clk100M       (Clk100M),
    .Rst_n         (Rst_n),
    .start         (start2),
    .tap           (tap2),
    .incLevel      (1'b0),
    .lose          (1'b0),
    .levelComplete (lc2),
    .difference    (diff2),
    .level         (level2),
    .target        (target2),
    .running       (running2),
    .gameOver      (gameOver2),
    .won           (won2)
  );

  function automatic int m_target(input int lvl);
    int t;
    t = 3 + 2 * lvl;
    return (t > 31) ? 31 : t;
  endfunction

  function automatic int m_diff(input int tgt, input int n);
    int c;
    c = (n > 31) ? 31 : n;
    return (tgt > c) ? tgt - c : c - tgt;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk100M);
    #1;
  endtask

  task automatic clr();
    start    = 1'b0;
    tap      = 1'b0;
    incLevel = 1'b0;
    lose     = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_running"}, running, !m_over);
    chk({tag, "_gameOver"}, gameOver, m_over);
    chk({tag, "_level"}, level, m_level);
    chk({tag, "_target"}, target, m_target(m_level));
    if (m_over) chk({tag, "_won"}, won, m_won);
  endtask

  // Called in the first RUN cycle; returns in the
  // levelComplete cycle.
  task automatic play_round(
    input string       tag,
    input logic [15:0] v,
    input bit          fuzz
  );
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      tap = v[i];
      if (v[i]) n++;
      if (fuzz) begin
        start    = 1'($urandom);
        incLevel = 1'($urandom);
        lose     = 1'($urandom);
      end
      chk({tag, "_lc_low"}, levelComplete, 1'b0);
      chk({tag, "_run"}, running, 1'b1);
      tick();
    end
    clr();
    g_diff = m_diff(m_target(m_level), n);
    chk({tag, "_lc"}, levelComplete, 1'b1);
    chk({tag, "_diff"}, difference, g_diff);
    chk({tag, "_not_run"}, running, 1'b0);
  endtask

  // Window cycles 1..7 after levelComplete; at=0
  // means no verdict.
  task automatic judge(
    input string tag,
    input int    at,
    input bit    inc,
    input bit    ls
  );
    for (int k = 1; k <= 7; k++) begin
      tick();
      tap      = 1'($urandom);
      incLevel = 1'b0;
      lose     = 1'b0;
      chk({tag, "_lc_pulse"}, levelComplete, 1'b0);
      chk({tag, "_diff_held"}, difference, g_diff);
      chk({tag, "_in_judge"}, running | gameOver, 1'b0);
      if (k == at) begin
        incLevel = inc;
        lose     = ls;
        break;
      end
    end
    tick();
    clr();
    if (at != 0 && ls) begin
      m_over = 1'b1;
      m_won  = 1'b0;
    end else if (at != 0 && inc) begin
      if (m_level == 7) begin
        m_over = 1'b1;
        m_won  = 1'b1;
      end else begin
        m_level++;
      end
    end
    check_state(tag);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_lc"}, levelComplete, 1'b0);
    chk({tag, "_diff"}, difference, 5'd0);
    chk({tag, "_level"}, level, 4'd0);
    chk({tag, "_target"}, target, 5'd3);
    chk({tag, "_running"}, running, 1'b0);
    chk({tag, "_gameOver"}, gameOver, 1'b0);
    chk({tag, "_won"}, won, 1'b0);
  endtask

  initial begin
    clr();
    start2 = 1'b0;
    tap2   = 1'b0;
    Rst_n  = 1'b0;
    m_level = 0;
    m_won   = 1'b0;
    m_over  = 1'b0;
    g_diff  = 0;
    #12;
    reset_outputs("rst");
    Rst_n = 1'b1;
    tick();
    chk("idle_run", running, 1'b0);
    chk("idle_over", gameOver, 1'b0);

    // Game 1: timeout, expiry tap, full win.
    start = 1'b1;
    tick();
    clr();
    check_state("g1_start");
    play_round("r0_five", 16'h001F, 1'b0);
    judge("timeout", 0, 1'b0, 1'b0);
    play_round("r0_expiry", 16'h8208, 1'b1);
    judge("last_cycle", 7, 1'b1, 1'b0);
    for (int l = 1; l <= 7; l++) begin
      play_round("rnd", 16'($urandom), 1'b1);
      judge("adv", int'($urandom_range(1, 7)),
            1'b1, 1'b0);
    end
    chk("win_won", won, 1'b1);
    chk("win_over", gameOver, 1'b1);
    incLevel = 1'b1;
    lose     = 1'b1;
    tick();
    clr();
    check_state("over_ignore");
    start = 1'b1;
    tick();
    clr();
    chk("to_idle_over", gameOver, 1'b0);
    chk("to_idle_run", running, 1'b0);

    // Game 2: simultaneous verdicts, lose wins.
    m_level = 0;
    m_over  = 1'b0;
    start = 1'b1;
    tick();
    clr();
    check_state("g2_start");
    play_round("g2", 16'($urandom), 1'b1);
    judge("both", int'($urandom_range(1, 7)),
          1'b1, 1'b1);
    chk("lose_won", won, 1'b0);
    chk("lose_over", gameOver, 1'b1);
    start = 1'b1;
    tick();
    clr();

    // Game 3: asynchronous reset mid-round.
    m_level = 0;
    m_over  = 1'b0;
    start = 1'b1;
    tick();
    clr();
    play_round("g3", 16'h0001, 1'b0);
    judge("g3_adv", 3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tap = 1'($urandom);
      tick();
    end
    clr();
    #2;
    Rst_n = 1'b0;
    #1;
    reset_outputs("async");
    tick();
    Rst_n = 1'b1;
    tick();
    chk("post_rst_idle", running, 1'b0);
    m_level = 0;
    start = 1'b1;
    tick();
    clr();
    play_round("post_rst", 16'h00FF, 1'b0);

    // Saturation on the long-round instance.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 48; i++) begin
      tap2 = (i < 40);
      chk("sat_lc_low", lc2, 1'b0);
      tick();
    end
    tap2 = 1'b0;
    chk("sat_lc", lc2, 1'b1);
    chk("sat_diff", diff2, 5'd28);
    tick();
    chk("sat_lc_once", lc2, 1'b0);
    chk("sat_diff_held", diff2, 5'd28);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/round_controller.md
# round_controller

Drives one game round at a time toward the judging block. Counts player taps against a per-level target for a fixed round duration, then pulses `levelComplete` with a saturated absolute `difference`. Waits for the `incLevel`/`lose` verdict and advances the level, repeats the level, or ends the game. Sits between the input debouncer/tap source and the judge, and also feeds the display with level and target.

## Interface
- `TICKS_PER_ROUND`, 16: round length in `Clk100M` cycles; must be ≥ 2.
- `MAX_LEVEL`, 7: last level index; passing it ends the game with a win.
- `RESP_TIMEOUT`, 8: cycles to wait for a verdict before repeating the level.
- `BASE_TARGET`, 3: target tap count at level 0.

- `Clk100M`  in  1  sole clock, rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; leaves IDLE or OVER.
- `tap`  in  1  single-cycle tap pulse, already debounced.
- `incLevel`  in  1  verdict: advance.
- `lose`  in  1  verdict: game lost.
- `levelComplete`  out  1  one-cycle pulse at round end.
- `difference`  out  5  |target − taps|, saturated at 31.
- `level`  out  4  current level index.
- `target`  out  5  current target = min(BASE_TARGET + 2·level, 31).
- `running`  out  1  high in RUN.
- `gameOver`  out  1  high in OVER.
- `won`  out  1  valid in OVER; 1 = passed `MAX_LEVEL`.

## Operation
- States:
  - IDLE: `start` → RUN with level 0.
  - RUN: count taps; timer expiry → JUDGE.
  - JUDGE: wait for a verdict.
    - `lose` → OVER with `won`=0.
    - `incLevel` with level < `MAX_LEVEL` → RUN with level+1.
    - `incLevel` with level = `MAX_LEVEL` → OVER with `won`=1.
    - Timeout → RUN at the same level.
  - OVER: `start` → IDLE.
- Entering RUN: tap count cleared to 0; timer loaded with `TICKS_PER_ROUND`−1.
- Tap counter is 5 bits and saturates at 31. No wrap.
- A `tap` on the expiry cycle is counted. Taps outside RUN are ignored.
- `difference` is computed from the final count, including a tap on the expiry cycle. It is registered and held until the next `levelComplete`.
- `incLevel` and `lose` are ignored outside JUDGE.
- In JUDGE, if both arrive in the same cycle, `lose` wins.
- `start` is ignored in RUN and JUDGE.
- `target` is registered on level change.

## Timing
- Reset state: IDLE; all outputs 0.
  - Exception: `target` resets to `BASE_TARGET`.
- Asynchronous reset mid-round: immediate return to IDLE. Tap count, timer, level and `difference` are cleared.
- RUN lasts exactly `TICKS_PER_ROUND` cycles.
- `levelComplete` is high in the first JUDGE cycle only, one cycle after the expiry cycle. `difference` is valid in that same cycle.
- The judge is registered, so verdicts are sampled from the cycle after `levelComplete`.
- Response window is `RESP_TIMEOUT` cycles, counted from the `levelComplete` cycle. With no verdict, the transition to RUN happens on the cycle after the window closes.
- A verdict in the last window cycle is honoured, not treated as a timeout.
- All state transitions are registered: one edge after the causing input.

## Structure
- Shared package `game_pkg`:
  - state enum (IDLE, RUN, JUDGE, OVER);
  - 5-bit count type;
  - `SAT_MAX` = 31;
  - target function.
- Sub-module `round_timer`: loadable down-counter with an `expire` pulse. Reused for both the round timer and the response timeout.

## Test plan
- Defaults. `start`, then 5 taps at level 0 (target 3) → `levelComplete` 17 cycles after `start`, `difference`=2.
- 40 taps in a round → count saturates at 31; `difference`=28.
- Tap on expiry cycle plus 2 earlier taps, target 3 → `difference`=0.
- `incLevel` and `lose` in the same JUDGE cycle → OVER, `won`=0, `gameOver`=1.
- No verdict for 8 cycles → RUN again at the same level, tap count 0; a second `levelComplete` follows 16 cycles later.
- `incLevel` at level 7 → OVER with `won`=1.
- Separately, assert `Rst_n`=0 mid-RUN → all outputs 0 within the same cycle, state IDLE.
